fp_unpack_seq: RTL and testbench
================================

FP_UNPACK_SEQ -- requirements
Module: fp_unpack_seq

Interface
REQ-001 SHALL have parameter EW, default 5, exponent field width.
REQ-002 SHALL have parameter MW, default 10, stored fraction width; input word width is W=1+EW+MW.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  x_in is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts x_in this cycle.
REQ-007 SHALL have port x_in  input  W  packed IEEE-style operand {sign, exponent, fraction}.
REQ-008 SHALL have port out_valid  output  1  unpacked result is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-010 SHALL have port xs  output  1  sign.
REQ-011 SHALL have port xe  output  EW+2  signed biased exponent, two's complement.
REQ-012 SHALL have port xm  output  MW+1  significand including hidden bit.
REQ-013 SHALL have ports xsubnorm, xzero, xinf, xnan, xsnan  output  1 each  class flags of the original operand.

Function
REQ-014 SHALL implement FSM states IDLE, NORM, DONE.
REQ-015 in_ready SHALL be 1 in IDLE, or in DONE when out_ready=1; otherwise 0.
REQ-016 Acceptance (in_valid & in_ready) SHALL register xs=x_in[W-1], xe=exp+(exp==0), xm={exp!=0, frac}, and the flags.
REQ-017 Flags: xsubnorm=exp==0 & frac!=0; xzero=exp==0 & frac==0; xinf=exp all-ones & frac==0; xnan=exp all-ones & frac!=0; xsnan=xnan & frac[MW-1]==0.
REQ-018 On acceptance, a non-subnormal operand SHALL go to DONE; out_valid=1 the next cycle (latency 1).
REQ-019 On acceptance, a subnormal operand SHALL go to NORM (when normalization is compiled in, REQ-029).
REQ-020 Each NORM cycle SHALL do xm<=xm<<1 and xe<=xe-1.
REQ-021 NORM SHALL go to DONE in the cycle the shifted xm[MW] becomes 1; shifts = leading zeros of frac (MW bits) + 1.
REQ-022 Subnormal latency SHALL be 1+shifts cycles from acceptance to out_valid; xsubnorm SHALL stay 1 after normalization.
REQ-023 In DONE, out_valid=1 and all outputs SHALL hold stable while out_ready=0.
REQ-024 DONE with out_ready=1 and in_valid=1 SHALL accept the new operand in the same cycle (back-to-back, no bubble).
REQ-025 DONE with out_ready=1 and in_valid=0 SHALL return to IDLE with out_valid=0.
REQ-026 In IDLE and NORM, out_valid SHALL be 0; in NORM, in_valid SHALL be ignored.

Reset
REQ-027 Asserting reset, including mid-NORM, SHALL force IDLE, out_valid=0, xs=0, xe=0, xm=0 and all flags to 0, and SHALL discard any operand in flight.
REQ-028 in_ready SHALL read 1 while reset is asserted and in the first cycle after release.

Configuration
REQ-029 With macro FP_UNPACK_NORM_EN defined, subnormals SHALL be normalized per REQ-019..REQ-022.
REQ-030 Without FP_UNPACK_NORM_EN, the NORM state and its logic SHALL be absent; subnormals SHALL go to DONE with xe=1 and xm={0,frac} at latency 1.

Structure
REQ-031 Package fp_unpack_pkg SHALL hold the state enum typedef and a class-flag struct typedef.
REQ-032 Classification SHALL be a combinational sub-module fp_classify (x_in -> sign, exp, significand, flags), instantiated once.

Verification (EW=5, MW=10)
REQ-033 0x3C00, out_ready=1 -> next cycle: out_valid=1, xs=0, xe=15, xm=0x400, all flags 0.
REQ-034 0x0001 with FP_UNPACK_NORM_EN -> 10 NORM cycles; out_valid 11 cycles after acceptance; xe=-9, xm=0x400, xsubnorm=1. Without the macro -> xe=1, xm=0x001, latency 1.
REQ-035 0x7D00 -> xnan=1, xsnan=1, xm=0x500, xe=31. 0x7E00 -> xnan=1, xsnan=0. 0x8000 -> xs=1, xzero=1, xe=1, xm=0.
REQ-036 0x3C00 accepted, out_ready=0 for 3 cycles -> outputs held and in_ready=0 throughout; then out_ready=1 with 0x4000 pending -> 0x4000 accepted that cycle; xe=16 the next cycle.
REQ-037 Reset asserted 4 cycles into normalizing 0x0001 -> immediately IDLE and all outputs 0; after release, 0x3C00 completes normally at latency 1.

Source files
------------

// File: rtl/fp_unpack_pkg.sv
// ============================================================================
//  Module      : fp_unpack_pkg
//  Description : Shared types for the sequential floating-point unpacker:
//                FSM state encoding and the operand class-flag bundle.
//                Optional feature macro: FP_UNPACK_NORM_EN (adds NORM state).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_unpack_pkg;

`ifdef FP_UNPACK_NORM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  // Class of the original packed operand; exactly one of subnorm/zero/inf/nan
  // is set for non-normal operands, snan qualifies nan.
  typedef struct packed {
    logic subnorm;
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } fp_class_t;

endpackage

`default_nettype wire

// File: rtl/fp_unpack_seq_classify.sv
// ============================================================================
//  Module      : fp_classify
//  Description : Combinational field split and classification of a packed
//                IEEE-style operand {sign, exponent, fraction}.
//  Ports       : x_in  - packed operand (1+EW+MW bits)
//                sign  - sign bit
//                exp_f - raw biased exponent field
//                sig   - significand with hidden bit {exp!=0, frac}
//                flags - class flags (subnorm, zero, inf, nan, snan)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_classify
  import fp_unpack_pkg::*;
#(
  parameter int EW = 5,
  parameter int MW = 10
) (
  input  logic [EW+MW:0] x_in,
  output logic           sign,
  output logic [EW-1:0]  exp_f,
  output logic [MW:0]    sig,
  output fp_class_t      flags
);

  logic [MW-1:0] w_frac;
  logic          w_exp_zero;
  logic          w_exp_ones;
  logic          w_frac_zero;

  assign sign        = x_in[EW+MW];
  assign exp_f       = x_in[EW+MW-1:MW];
  assign w_frac      = x_in[MW-1:0];
  assign w_exp_zero  = (exp_f == '0);
  assign w_exp_ones  = (exp_f == '1);
  assign w_frac_zero = (w_frac == '0);

  assign sig = {~w_exp_zero, w_frac};

  assign flags.subnorm = w_exp_zero & ~w_frac_zero;
  assign flags.zero    = w_exp_zero &  w_frac_zero;
  assign flags.inf     = w_exp_ones &  w_frac_zero;
  assign flags.nan     = w_exp_ones & ~w_frac_zero;
  // Quiet bit is the fraction MSB; a NaN with it clear is signalling.
  assign flags.snan    = w_exp_ones & ~w_frac_zero & ~w_frac[MW-1];

endmodule

`default_nettype wire

// File: rtl/fp_unpack_seq.sv
// ============================================================================
//  Module      : fp_unpack_seq
//  Description : Sequential unpacker for packed IEEE-style operands with a
//                valid/ready handshake on both sides. Produces sign, signed
//                biased exponent, significand with hidden bit and class flags.
//                With FP_UNPACK_NORM_EN defined, subnormal operands are
//                normalized one bit per cycle in a NORM state.
//  Ports       : clk, reset (async, active-high)
//                in_valid/in_ready/x_in      - operand input handshake
//                out_valid/out_ready         - result output handshake
//                xs, xe, xm                  - sign, exponent, significand
//                xsubnorm/xzero/xinf/xnan/xsnan - class of original operand
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_unpack_seq
  import fp_unpack_pkg::*;
#(
  parameter int EW = 5,
  parameter int MW = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EW+MW:0]       x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 xs,
  output logic signed [EW+1:0] xe,
  output logic [MW:0]          xm,
  output logic                 xsubnorm,
  output logic                 xzero,
  output logic                 xinf,
  output logic                 xnan,
  output logic                 xsnan
);

  // Classification of the incoming operand
  logic          w_sign;
  logic [EW-1:0] w_exp;
  logic [MW:0]   w_sig;
  fp_class_t     w_flags;
  logic [EW+1:0] w_xe_init;
  logic          w_accept;

  fp_classify #(
    .EW (EW),
    .MW (MW)
  ) u_classify (
    .x_in  (x_in),
    .sign  (w_sign),
    .exp_f (w_exp),
    .sig   (w_sig),
    .flags (w_flags)
  );

  // Subnormals share the exponent of the smallest normal (exp field 0 -> 1).
  assign w_xe_init = {2'b00, w_exp} + {{(EW+1){1'b0}}, (w_exp == '0)};

  // Registered state
  state_t        state_q, state_d;
  logic          xs_q, xs_d;
  logic [EW+1:0] xe_q, xe_d;
  logic [MW:0]   xm_q, xm_d;
  fp_class_t     flags_q, flags_d;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    xm_d    = xm_q;
    flags_d = flags_q;

    case (state_q)
`ifdef FP_UNPACK_NORM_EN
      NORM: begin
        xm_d = xm_q << 1;
        xe_d = xe_q - {{(EW+1){1'b0}}, 1'b1};
        // Leave once the bit shifted into the hidden position is set.
        if (xm_q[MW-1]) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready && !in_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
      end
    endcase

    // Acceptance covers both IDLE and the back-to-back DONE case.
    if (w_accept) begin
      xs_d    = w_sign;
      xe_d    = w_xe_init;
      xm_d    = w_sig;
      flags_d = w_flags;
`ifdef FP_UNPACK_NORM_EN
      state_d = w_flags.subnorm ? NORM : DONE;
`else
      state_d = DONE;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      xs_q    <= 1'b0;
      xe_q    <= '0;
      xm_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      xm_q    <= xm_d;
      flags_q <= flags_d;
    end
  end

  assign xs       = xs_q;
  assign xe       = xe_q;
  assign xm       = xm_q;
  assign xsubnorm = flags_q.subnorm;
  assign xzero    = flags_q.zero;
  assign xinf     = flags_q.inf;
  assign xnan     = flags_q.nan;
  assign xsnan    = flags_q.snan;

endmodule

`default_nettype wire

// File: tb/tb_fp_unpack_seq.sv
// ============================================================================
//  Module      : tb_fp_unpack_seq
//  Description : Self-checking bench for fp_unpack_seq (EW=5, MW=10) with
//                directed operands and randomized traffic against a
//                value-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_unpack_seq;

  localparam int EW = 5;
  localparam int MW = 10;
  localparam int W  = 1 + EW + MW;
  localparam int LAT_LIMIT = 40;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         x_in;
  logic                 out_valid;
  logic                 out_ready;
  logic                 xs;
  logic signed [EW+1:0] xe;
  logic [MW:0]          xm;
  logic                 xsubnorm, xzero, xinf, xnan, xsnan;
  logic [4:0]           obs_f;

  int errors = 0;
  int checks = 0;

  assign obs_f = {xsubnorm, xzero, xinf, xnan, xsnan};

  always #5 clk = ~clk;

  fp_unpack_seq #(.EW(EW), .MW(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xs        (xs),
    .xe        (xe),
    .xm        (xm),
    .xsubnorm  (xsubnorm),
    .xzero     (xzero),
    .xinf      (xinf),
    .xnan      (xnan),
    .xsnan     (xsnan)
  );

  typedef struct {
    logic       s;
    int         e;
    logic [MW:0] m;
    logic [4:0] f;
    int         lat;
  } exp_t;

  // Reference: value-level unpacking; subnormals are scaled up by doubling
  // until the significand reaches 2^MW, one cycle per doubling.
  function automatic exp_t model(input logic [W-1:0] x);
    exp_t r;
    int ex, fr, m, k;
    ex = int'(x[W-2:MW]);
    fr = int'(x[MW-1:0]);
    r.s = x[W-1];
    r.f[4] = (ex == 0) && (fr != 0);
    r.f[3] = (ex == 0) && (fr == 0);
    r.f[2] = (ex == 31) && (fr == 0);
    r.f[1] = (ex == 31) && (fr != 0);
    r.f[0] = (ex == 31) && (fr != 0) && (fr < 512);
    r.lat = 1;
    if (ex == 0) begin
      r.e = 1;
      m = fr;
`ifdef FP_UNPACK_NORM_EN
      if (fr != 0) begin
        k = 0;
        while (m < 1024) begin
          m = m * 2;
          k = k + 1;
        end
        r.e = 1 - k;
        r.lat = 1 + k;
      end
`endif
    end else begin
      r.e = ex;
      m = 1024 + fr;
    end
    r.m = (MW+1)'(m);
    return r;
  endfunction

  function automatic logic [W-1:0] gen_op();
    logic [W-1:0] x;
    logic [MW-1:0] fr;
    logic [EW-1:0] ex;
    x  = W'($urandom);
    fr = MW'($urandom);
    case ($urandom_range(0, 5))
      0: ;
      1: begin
        fr = fr >> $urandom_range(0, 9);
        if (fr == '0) fr = 1;
        x = {x[W-1], {EW{1'b0}}, fr};
      end
      2: x = {x[W-1], {(W-1){1'b0}}};
      3: begin
        if ($urandom_range(0, 1) == 0) fr = '0;
        x = {x[W-1], {EW{1'b1}}, fr};
      end
      default: begin
        ex = EW'($urandom_range(1, 30));
        x = {x[W-1], ex, fr};
      end
    endcase
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; x_in = '0; out_ready = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || xs !== 1'b0 || xe !== '0 || xm !== '0 || obs_f !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%b xs=%b xe=%0d xm=%h f=%b, need all 0",
               out_valid, xs, xe, xm, obs_f);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
    step(); step();
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got in_ready=%b out_valid=%b need 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ops [6];
    logic         es  [6];
    int           ee  [6];
    logic [MW:0]  em  [6];
    logic [4:0]   ef  [6];
    int           el  [6];
    int lat;
    ops[0] = 16'h3C00; es[0] = 0; ee[0] = 15; em[0] = 11'h400; ef[0] = 5'b00000; el[0] = 1;
`ifdef FP_UNPACK_NORM_EN
    ops[1] = 16'h0001; es[1] = 0; ee[1] = -9; em[1] = 11'h400; ef[1] = 5'b10000; el[1] = 11;
`else
    ops[1] = 16'h0001; es[1] = 0; ee[1] = 1;  em[1] = 11'h001; ef[1] = 5'b10000; el[1] = 1;
`endif
    ops[2] = 16'h7D00; es[2] = 0; ee[2] = 31; em[2] = 11'h500; ef[2] = 5'b00011; el[2] = 1;
    ops[3] = 16'h7E00; es[3] = 0; ee[3] = 31; em[3] = 11'h600; ef[3] = 5'b00010; el[3] = 1;
    ops[4] = 16'h8000; es[4] = 1; ee[4] = 1;  em[4] = 11'h000; ef[4] = 5'b01000; el[4] = 1;
    ops[5] = 16'h7C00; es[5] = 0; ee[5] = 31; em[5] = 11'h400; ef[5] = 5'b00100; el[5] = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; x_in = ops[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir_in_ready[%0d]: got %b need 1", i, in_ready);
      end
      step();
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < LAT_LIMIT) begin
        checks++;
        if (in_ready !== 1'b0 && el[i] > 1) begin
          errors++;
          $display("FAIL dir_norm_in_ready[%0d]: got %b need 0", i, in_ready);
        end
        step();
        lat++;
      end
      checks++;
      if (lat !== el[i] || xs !== es[i] || int'(xe) !== ee[i] || xm !== em[i] || obs_f !== ef[i]) begin
        errors++;
        $display("FAIL dir_op[%h]: got lat=%0d xs=%b xe=%0d xm=%h f=%b need lat=%0d xs=%b xe=%0d xm=%h f=%b",
                 ops[i], lat, xs, xe, xm, obs_f, el[i], es[i], ee[i], em[i], ef[i]);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir_idle[%0d]: got out_valid=%b need 0", i, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; x_in = 16'h3C00;
    step();
    x_in = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(xe) !== 15 || xm !== 11'h400 || xs !== 1'b0 || obs_f !== 5'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got ov=%b ir=%b xe=%0d xm=%h need ov=1 ir=0 xe=15 xm=400",
                 i, out_valid, in_ready, xe, xm);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b need 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || int'(xe) !== 16 || xm !== 11'h400) begin
      errors++;
      $display("FAIL stall_next: got ov=%b xe=%0d xm=%h need ov=1 xe=16 xm=400", out_valid, xe, xm);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle: got out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_norm();
    int lat;
    out_ready = 1'b0;
    in_valid = 1'b1; x_in = 16'h0001;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || xs !== 1'b0 || xe !== '0 || xm !== '0 || obs_f !== 5'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midnorm_reset: got ov=%b xe=%0d xm=%h f=%b ir=%b need zeros and ir=1",
               out_valid, xe, xm, obs_f, in_ready);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midnorm_release: got ir=%b ov=%b need 1/0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; x_in = 16'h3C00;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < LAT_LIMIT) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 1 || int'(xe) !== 15 || xm !== 11'h400 || obs_f !== 5'b0) begin
      errors++;
      $display("FAIL midnorm_after: got lat=%0d xe=%0d xm=%h f=%b need lat=1 xe=15 xm=400 f=0",
               lat, xe, xm, obs_f);
    end
    step();
  endtask

  task automatic test_random();
    exp_t r;
    logic [W-1:0] op;
    int lat, stall;
    for (int n = 0; n < 150; n++) begin
      op = gen_op();
      r = model(op);
      in_valid = 1'b1; x_in = op;
      out_ready = 1'($urandom_range(0, 1));
      step();
      in_valid = 1'b0;
      x_in = W'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < LAT_LIMIT) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        lat++;
      end
      checks++;
      if (lat !== r.lat || xs !== r.s || int'(xe) !== r.e || xm !== r.m || obs_f !== r.f) begin
        errors++;
        $display("FAIL rand_op[%h]: got lat=%0d xs=%b xe=%0d xm=%h f=%b need lat=%0d xs=%b xe=%0d xm=%h f=%b",
                 op, lat, xs, xe, xm, obs_f, r.lat, r.s, r.e, r.m, r.f);
      end
      stall = $urandom_range(0, 3);
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'($urandom_range(0, 1));
        step();
        checks++;
        if (out_valid !== 1'b1 || int'(xe) !== r.e || xm !== r.m || obs_f !== r.f || xs !== r.s) begin
          errors++;
          $display("FAIL rand_hold[%h]: got ov=%b xe=%0d xm=%h f=%b need ov=1 xe=%0d xm=%h f=%b",
                   op, out_valid, xe, xm, obs_f, r.e, r.m, r.f);
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle[%h]: got out_valid=%b need 0", op, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ops [20];
    exp_t r;
    int lat;
    for (int i = 0; i < 20; i++) ops[i] = gen_op();
    out_ready = 1'b1;
    in_valid = 1'b1; x_in = ops[0];
    step();
    for (int i = 0; i < 20; i++) begin
      r = model(ops[i]);
      if (i < 19) x_in = ops[i+1];
      else in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < LAT_LIMIT) begin
        step();
        lat++;
      end
      checks++;
      if (lat !== r.lat || xs !== r.s || int'(xe) !== r.e || xm !== r.m || obs_f !== r.f || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_op[%h]: got lat=%0d xs=%b xe=%0d xm=%h f=%b ir=%b need lat=%0d xs=%b xe=%0d xm=%h f=%b ir=1",
                 ops[i], lat, xs, xe, xm, obs_f, in_ready, r.lat, r.s, r.e, r.m, r.f);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got out_valid=%b need 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_norm();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
